// File: rtl/counter_b4_core_pkg.sv
// Shared mode encodings and width default
// for the 4-bit multi-mode counter.
`ifndef COUNTER_B4_CORE_PKG_SV
`define COUNTER_B4_CORE_PKG_SV
package counter_b4_core_pkg;
  localparam int NBITS_DEF = 4;
  localparam logic [1:0] MODE_UP1  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage
`endif

// File: rtl/counter_b4_next.sv
// Combinational next-state function,
// shared with structural models and checkers.
import counter_b4_core_pkg::*;

module counter_b4_next #(
  parameter int NBITS   = NBITS_DEF,
  parameter int STEP_DN = 3
) (
  input  logic [NBITS-1:0] i_q,
  input  logic [1:0]       i_mode,
  input  logic [NBITS-1:0] i_d,
  output logic [NBITS-1:0] o_next_q,
  output logic             o_next_rco,
  output logic             o_next_load
);
  localparam logic [NBITS-1:0] W_STEP = NBITS'(STEP_DN);
  localparam logic [NBITS-1:0] W_MAX  = {NBITS{1'b1}};

  always_comb begin
    o_next_q    = {NBITS{1'bx}};
    o_next_rco  = 1'bx;
    o_next_load = 1'bx;
    case (i_mode)
      MODE_UP1: begin
        o_next_q    = i_q + 1'b1;
        o_next_rco  = (i_q == W_MAX);
        o_next_load = 1'b0;
      end
      MODE_DN1: begin
        o_next_q    = i_q - 1'b1;
        o_next_rco  = (i_q == '0);
        o_next_load = 1'b0;
      end
      MODE_DN3: begin
        o_next_q    = i_q - W_STEP;
        o_next_rco  = (i_q < W_STEP);
        o_next_load = 1'b0;
      end
      MODE_LOAD: begin
        o_next_q    = i_d;
        o_next_rco  = 1'b0;
        o_next_load = 1'b1;
      end
      // X/Z mode propagates X so bench errors stay visible
      default: begin
        o_next_q    = {NBITS{1'bx}};
        o_next_rco  = 1'bx;
        o_next_load = 1'bx;
      end
    endcase
  end
endmodule

// File: rtl/counter_b4_core.sv
// Registered 4-bit multi-mode counter core:
// state, async reset and enable gating.
import counter_b4_core_pkg::*;

module counter_b4_core #(
  parameter int NBITS   = NBITS_DEF,
  parameter int STEP_DN = 3
) (
  input  logic             b4_clk,
  input  logic             b4_reset,
  input  logic             b4_enable,
  input  logic [1:0]       b4_mode,
  input  logic [NBITS-1:0] b4_D,
  output logic [NBITS-1:0] b4_Q,
  output logic             b4_rco,
  output logic             b4_load
);
  logic [NBITS-1:0] w_next_q;
  logic             w_next_rco;
  logic             w_next_load;

  counter_b4_next #(
    .NBITS  (NBITS),
    .STEP_DN(STEP_DN)
  ) u_next (
    .i_q        (b4_Q),
    .i_mode     (b4_mode),
    .i_d        (b4_D),
    .o_next_q   (w_next_q),
    .o_next_rco (w_next_rco),
    .o_next_load(w_next_load)
  );

  always_ff @(posedge b4_clk or posedge b4_reset) begin
    if (b4_reset) begin
      b4_Q    <= '0;
      b4_rco  <= 1'b0;
      b4_load <= 1'b0;
    end else begin
      case (b4_enable)
        1'b1: begin
          b4_Q    <= w_next_q;
          b4_rco  <= w_next_rco;
          b4_load <= w_next_load;
        end
        1'b0: begin
          b4_Q    <= b4_Q;
          b4_rco  <= 1'b0;
          b4_load <= 1'b0;
        end
        default: begin
          b4_Q    <= {NBITS{1'bx}};
          b4_rco  <= 1'bx;
          b4_load <= 1'bx;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_counter_b4_core.sv
// Scoreboard bench for counter_b4_core:
// directed vectors, queued expectations.
module tb_counter_b4_core;
  typedef struct packed {
    logic [3:0] q;
    logic       rco;
    logic       load;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       rco;
  logic       load;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_b4_core #(.NBITS(4), .STEP_DN(3)) dut (
    .b4_clk   (clk),
    .b4_reset (rst),
    .b4_enable(en),
    .b4_mode  (mode),
    .b4_D     (d),
    .b4_Q     (q),
    .b4_rco   (rco),
    .b4_load  (load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, ".Q"}, int'(q), int'(e.q));
    chk({nm, ".rco"}, int'(rco), int'(e.rco));
    chk({nm, ".load"}, int'(load), int'(e.load));
  endtask

  // drive on falling edge, queue what the next rising edge must produce
  task automatic step(input logic e, input logic [1:0] m,
                      input logic [3:0] dv, input logic [3:0] eq,
                      input logic er, input logic el);
    exp_t x;
    @(negedge clk);
    en = e;
    mode = m;
    d = dv;
    x.q = eq;
    x.rco = er;
    x.load = el;
    exp_q.push_back(x);
  endtask

  // monitor: compare after every rising edge that has a pending expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_out("cycle", e);
    end
  end

  initial begin
    exp_t z;
    z = '0;
    #1;
    chk_out("por", z);

    // reset mid-count
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++)
      step(1'b1, 2'b00, 4'd0, 4'(i), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", z);
    step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    exp_q.push_back(z);

    // up wrap 15 -> 0
    for (int i = 1; i <= 17; i++)
      step(1'b1, 2'b00, 4'd0, 4'(i % 16), (i == 16), 1'b0);

    // load 1 then down-1 wrap
    step(1'b1, 2'b11, 4'd1, 4'd1, 1'b0, 1'b1);
    step(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 4'd0, 4'd15, 1'b1, 1'b0);
    step(1'b1, 2'b01, 4'd0, 4'd14, 1'b0, 1'b0);

    // load 1010 then down-3 with borrow
    step(1'b1, 2'b11, 4'b1010, 4'd10, 1'b0, 1'b1);
    step(1'b1, 2'b10, 4'd0, 4'd7, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'd0, 4'd4, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'd0, 4'd1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'd0, 4'd14, 1'b1, 1'b0);
    step(1'b1, 2'b10, 4'd0, 4'd11, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'd0, 4'd8, 1'b0, 1'b0);

    // enable gating at Q=9
    step(1'b1, 2'b11, 4'd9, 4'd9, 1'b0, 1'b1);
    step(1'b0, 2'b00, 4'd0, 4'd9, 1'b0, 1'b0);
    step(1'b0, 2'b11, 4'd3, 4'd9, 1'b0, 1'b0);
    step(1'b0, 2'b00, 4'd0, 4'd9, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'd0, 4'd10, 1'b0, 1'b0);

    // back-to-back loads
    step(1'b1, 2'b11, 4'd5, 4'd5, 1'b0, 1'b1);
    step(1'b1, 2'b11, 4'd5, 4'd5, 1'b0, 1'b1);
    step(1'b1, 2'b11, 4'd12, 4'd12, 1'b0, 1'b1);
    step(1'b1, 2'b00, 4'd0, 4'd13, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end
endmodule
